mmio_timer: RTL and testbench

//  Memory-mapped countdown timer on the MEM-stage device bus (DEV space, byt_dv path).

---
 rtl/mmio_timer_if.sv | 12 +
 rtl/mmio_timer.sv | 155 +++++++++++++++
 tb/tb_mmio_timer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_if.sv
// Device-bus port bundle for mmio_timer: address/byte-enable/write-data in, read data and irq out.
// Read data is combinational; there is no handshake and no backpressure.
interface mmio_timer_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, byteen, wdata, input rdata, irq);
  modport slave  (input addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) raising a level irq; optional TIMER_PRESCALE_EN prescaler.
// Latency: reads combinational, writes commit at the next rising edge.
// Backpressure: none, the bus is always accepted.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
`ifdef TIMER_PRESCALE_EN
  ,
  parameter logic [7:0]  PRESCALE  = 8'd1
`endif
) (
  input  logic        clk,
  input  logic        reset,
  mmio_timer_if.slave bus
);

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        en_clr;
  logic        tick;

  logic [1:0]  offset;
  logic        hit;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        ctrl_en;
  logic        auto_reload;
  logic        unused_addr_lsb;

  assign offset          = bus.addr[3:2];
  assign hit             = (bus.addr[31:4] == BASE_ADDR[31:4]) && (offset != 2'd3);
  assign wr_ctrl         = hit && (bus.byteen != 4'h0) && (offset == OFF_CTRL);
  assign wr_preset       = hit && (bus.byteen != 4'h0) && (offset == OFF_PRESET);
  assign unused_addr_lsb = ^bus.addr[1:0];

  assign ctrl_en     = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
  localparam logic [7:0] PSC_LAST = (PRESCALE == 8'd0) ? 8'd0 : PRESCALE - 8'd1;

  logic [7:0] psc_q, psc_d;

  assign tick = (psc_q == PSC_LAST);

  // Runs only while counting stays in CNT; any exit (or LOAD) leaves it at zero.
  always_comb begin
    psc_d = 8'd0;
    if (state_q == CNT && ctrl_en && state_d == CNT) begin
      psc_d = tick ? 8'd0 : psc_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc_q <= 8'd0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    en_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_en) state_d = LOAD;
      end
      LOAD: begin
        count_d    = preset_q;
        state_d    = CNT;
        // A flag still set here can only be the auto-reload pulse from INT.
        irq_flag_d = 1'b0;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (count_q == 32'd0) begin
          state_d = INT;
        end else if (tick) begin
          count_d = count_q - 32'd1;
        end
      end
      INT: begin
        irq_flag_d = 1'b1;
        if (auto_reload) begin
          state_d = LOAD;
        end else begin
          en_clr  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_ctrl) irq_flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      // A bus write to CTRL takes priority over the one-shot EN clear.
      if (wr_ctrl) begin
        if (bus.byteen[0]) ctrl_q <= bus.wdata[3:0];
      end else if (en_clr) begin
        ctrl_q[0] <= 1'b0;
      end
      if (wr_preset) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.byteen[i]) preset_q[8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (hit) begin
      case (offset)
        OFF_CTRL:   bus.rdata = {28'd0, ctrl_q};
        OFF_PRESET: bus.rdata = preset_q;
        OFF_COUNT:  bus.rdata = count_q;
        default:    bus.rdata = 32'd0;
      endcase
    end
  end

  assign bus.irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: register-access vector table, hand-timed timer sequences,
// then random bus traffic against an elapsed-time reference model.
module tb_mmio_timer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mmio_timer_if bus ();

  mmio_timer #(.BASE_ADDR(32'h0000_7f00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] wa, input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] ra, input logic [31:0] ex, input string nm);
    vec_t v;
    v.waddr = wa; v.be = be; v.wdata = wd; v.raddr = ra; v.exp = ex; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    chk(name, {31'd0, bus.irq}, {31'd0, exp});
  endtask

  // Called at a negedge; the write commits at the following posedge; returns at the next negedge.
  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.addr = a; bus.byteen = be; bus.wdata = d;
    @(negedge clk);
    bus.byteen = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a; bus.byteen = 4'h0;
    #1;
    d = bus.rdata;
  endtask

  task automatic do_reset();
    bus.byteen = 4'h0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference model: timer tracked as a latched load value plus cycles elapsed since load.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_frozen;
  logic        m_flag;
  int          m_phase;   // 0 stopped, 1 reload due next edge, 2 running
  int unsigned m_load;
  int unsigned m_elapsed;

  function automatic logic [31:0] m_count();
    if (m_phase == 2) return (m_elapsed >= m_load) ? 32'd0 : m_load - m_elapsed;
    return m_frozen;
  endfunction

  function automatic logic m_hit(input logic [31:0] a);
    return (a[31:4] == 28'h00007f0) && (a[3:2] != 2'd3);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    if (!m_hit(a)) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count();
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_ctrl = 4'd0; m_preset = 32'd0; m_frozen = 32'd0; m_flag = 1'b0;
    m_phase = 0; m_load = 0; m_elapsed = 0;
  endtask

  task automatic m_step(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic wc, wp, en, autor, nflag, clr_en;
    wc     = m_hit(a) && (be != 4'h0) && (a[3:2] == 2'd0);
    wp     = m_hit(a) && (be != 4'h0) && (a[3:2] == 2'd1);
    en     = m_ctrl[0];
    autor  = (m_ctrl[2:1] == 2'b01);
    nflag  = m_flag;
    clr_en = 1'b0;
    if (m_phase == 0) begin
      if (en) m_phase = 1;
    end else if (m_phase == 1) begin
      m_load = m_preset; m_elapsed = 0; m_phase = 2; nflag = 1'b0;
    end else begin
      if (m_elapsed == m_load + 1) begin
        m_frozen = 32'd0; nflag = 1'b1;
        if (autor) m_phase = 1;
        else begin m_phase = 0; clr_en = 1'b1; end
      end else if (!en) begin
        m_frozen = m_count(); m_phase = 0;
      end else begin
        m_elapsed++;
      end
    end
    if (wc) nflag = 1'b0;
    m_flag = nflag;
    if (wc) begin
      if (be[0]) m_ctrl = d[3:0];
    end else if (clr_en) begin
      m_ctrl[0] = 1'b0;
    end
    if (wp) for (int i = 0; i < 4; i++) if (be[i]) m_preset[8*i +: 8] = d[8*i +: 8];
  endtask

  vec_t        vecs [13];
  logic [31:0] r;
  logic [31:0] cexp [12];
  logic        iexp [12];
  logic [31:0] addrs [5];

  initial begin
    bus.addr = 32'h0000_7f00; bus.byteen = 4'h0; bus.wdata = 32'd0;

    vecs[0]  = mk(32'h7f04, 4'hf, 32'h11223344, 32'h7f04, 32'h11223344, "preset_full");
    vecs[1]  = mk(32'h7f04, 4'h4, 32'h00aa0000, 32'h7f04, 32'h11aa3344, "preset_byte2");
    vecs[2]  = mk(32'h7f08, 4'hf, 32'hffffffff, 32'h7f08, 32'h00000000, "count_ro");
    vecs[3]  = mk(32'h7f0c, 4'hf, 32'hffffffff, 32'h7f0c, 32'h00000000, "reserved_rd");
    vecs[4]  = mk(32'h7f0c, 4'hf, 32'hffffffff, 32'h7f04, 32'h11aa3344, "reserved_noalias");
    vecs[5]  = mk(32'h7f14, 4'hf, 32'hdeadbeef, 32'h7f04, 32'h11aa3344, "offrange_nowrite");
    vecs[6]  = mk(32'h7f14, 4'h0, 32'h00000000, 32'h7f14, 32'h00000000, "offrange_rd");
    vecs[7]  = mk(32'h7f00, 4'hf, 32'hfffffff6, 32'h7f00, 32'h00000006, "ctrl_mask");
    vecs[8]  = mk(32'h7f00, 4'he, 32'hffffff01, 32'h7f00, 32'h00000006, "ctrl_upper_bytes");
    vecs[9]  = mk(32'h7f00, 4'h1, 32'h00000008, 32'h7f00, 32'h00000008, "ctrl_byte0");
    vecs[10] = mk(32'h7f07, 4'h3, 32'h0000beef, 32'h7f04, 32'h11aabeef, "addr_lsb_ignored");
    vecs[11] = mk(32'h7f04, 4'h0, 32'hffffffff, 32'h7f04, 32'h11aabeef, "byteen_zero");
    vecs[12] = mk(32'h7f00, 4'h1, 32'h00000000, 32'h7f00, 32'h00000000, "ctrl_clear");

    // Reset state
    do_reset();
    rd(32'h7f00, r); chk("rst_ctrl", r, 32'd0);
    rd(32'h7f04, r); chk("rst_preset", r, 32'd0);
    rd(32'h7f08, r); chk("rst_count", r, 32'd0);
    chk_irq("rst_irq", 1'b0);

    // Register access table (timer stays disabled)
    foreach (vecs[i]) begin
      wr(vecs[i].waddr, vecs[i].be, vecs[i].wdata);
      rd(vecs[i].raddr, r);
      chk(vecs[i].name, r, vecs[i].exp);
    end

    // One-shot: PRESET=5, CTRL=9 at E0
    do_reset();
    wr(32'h7f04, 4'hf, 32'd5);
    wr(32'h7f00, 4'hf, 32'h9);
    @(negedge clk); rd(32'h7f08, r); chk("os_count_e1", r, 32'd0);
    @(negedge clk); rd(32'h7f08, r); chk("os_count_e2", r, 32'd5);
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk); rd(32'h7f08, r); chk("os_count_run", r, 32'(7 - k));
    end
    @(negedge clk); chk_irq("os_irq_e8", 1'b0);
    @(negedge clk); chk_irq("os_irq_e9", 1'b1);
    rd(32'h7f00, r); chk("os_ctrl_after", r, 32'h8);
    repeat (3) @(negedge clk);
    chk_irq("os_irq_sticky", 1'b1);
    rd(32'h7f08, r); chk("os_count_hold0", r, 32'd0);
    wr(32'h7f00, 4'hf, 32'h0);
    chk_irq("os_irq_cleared", 1'b0);

    // Reset mid-count at COUNT=3
    do_reset();
    wr(32'h7f04, 4'hf, 32'd5);
    wr(32'h7f00, 4'hf, 32'h9);
    repeat (4) @(negedge clk);
    rd(32'h7f08, r); chk("rstmid_count3", r, 32'd3);
    reset = 1'b0;
    #1;
    rd(32'h7f08, r); chk("rstmid_count0", r, 32'd0);
    chk_irq("rstmid_irq", 1'b0);
    @(negedge clk); reset = 1'b1;

    // PRESET=0: LOAD, CNT, INT with no decrements; then async reset drops irq
    do_reset();
    wr(32'h7f00, 4'hf, 32'h9);
    @(negedge clk);
    @(negedge clk); rd(32'h7f08, r); chk("p0_count", r, 32'd0);
    @(negedge clk); chk_irq("p0_irq_int", 1'b0);
    @(negedge clk); chk_irq("p0_irq_set", 1'b1);
    reset = 1'b0;
    #1;
    chk_irq("p0_irq_async_drop", 1'b0);
    rd(32'h7f00, r); chk("p0_ctrl_rst", r, 32'd0);
    @(negedge clk); reset = 1'b1;

    // Auto-reload: PRESET=2, CTRL=0xb
    do_reset();
    wr(32'h7f04, 4'hf, 32'd2);
    wr(32'h7f00, 4'hf, 32'hb);
    cexp = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2};
    iexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rd(32'h7f08, r);
      chk("ar_count", r, cexp[k]);
      chk_irq("ar_irq", iexp[k]);
    end

    // Pause: PRESET=10, EN cleared so COUNT holds at 6, then re-enable reloads
    do_reset();
    wr(32'h7f04, 4'hf, 32'd10);
    wr(32'h7f00, 4'hf, 32'h9);
    repeat (5) @(negedge clk);
    rd(32'h7f08, r); chk("pause_count7", r, 32'd7);
    wr(32'h7f00, 4'hf, 32'h8);
    for (int k = 0; k < 3; k++) begin
      rd(32'h7f08, r); chk("pause_hold6", r, 32'd6);
      @(negedge clk);
    end
    wr(32'h7f00, 4'hf, 32'h9);
    @(negedge clk); rd(32'h7f08, r); chk("pause_load_cycle", r, 32'd6);
    @(negedge clk); rd(32'h7f08, r); chk("pause_reload10", r, 32'd10);
    @(negedge clk); rd(32'h7f08, r); chk("pause_run9", r, 32'd9);

    // Collision: CTRL write in the INT cycle
    do_reset();
    wr(32'h7f04, 4'hf, 32'd1);
    wr(32'h7f00, 4'hf, 32'h9);
    repeat (4) @(negedge clk);
    chk_irq("col_irq_int", 1'b0);
    wr(32'h7f00, 4'hf, 32'h9);
    rd(32'h7f00, r); chk("col_ctrl_en_kept", r, 32'h9);
    chk_irq("col_irq_clear", 1'b0);
    @(negedge clk); rd(32'h7f08, r); chk("col_load_cycle", r, 32'd0);
    @(negedge clk); rd(32'h7f08, r); chk("col_reload", r, 32'd1);
    repeat (3) @(negedge clk);
    chk_irq("col_second_irq", 1'b1);

    // Random traffic against the reference model
    addrs = '{32'h7f00, 32'h7f04, 32'h7f08, 32'h7f0c, 32'h7f14};
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a, d;
      logic [3:0]  be;
      a  = addrs[$urandom_range(0, 4)];
      be = 4'h0;
      d  = 32'd0;
      if ($urandom_range(0, 15) == 0) begin
        be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
        if (a[3:2] == 2'd0) begin
          d = $urandom;
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        end else begin
          d = 32'($urandom_range(0, 6));
        end
      end
      bus.addr = a; bus.byteen = be; bus.wdata = d;
      #1;
      chk("rnd_rdata", bus.rdata, m_rdata(a));
      chk_irq("rnd_irq", m_flag & m_ctrl[3]);
      m_step(a, be, d);
      @(negedge clk);
    end
    bus.byteen = 4'h0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
